cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Round-robin arbiter for the common data bus (CDB) that writes results back into the processor's register file and reservation stations. Functional units (ALU, branch, load, store-address) raise completed results with a valid/ready handshake. The arbiter grants at most one unit per cycle and drives a registered single-entry CDB broadcast stage. Downstream backpressure and pipeline flush are supported.

Parameters:
NUM_REQ, 4, number of requesting functional units (2..8)
DATA_WIDTH, 32, result width
TAG_WIDTH, 4, destination tag width (tag 0 = x0, no architectural write)

Ports:
clk_100mhz  input  1  system clock, 100 MHz
rst_in  input  1  synchronous, active-high reset
req_valid_in  input  NUM_REQ  per-unit result valid
req_data_in  input  NUM_REQ*DATA_WIDTH  packed results, unit i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_tag_in  input  NUM_REQ*TAG_WIDTH  packed destination tags, same packing
req_ready_out  output  NUM_REQ  one-hot grant; unit i's result accepted this cycle
cdb_ready_in  input  1  consumer accepts current broadcast
flush_in  input  1  mispredict flush; discard pending broadcast
cdb_valid_out  output  1  broadcast valid
cdb_data_out  output  DATA_WIDTH  broadcast result
cdb_tag_out  output  TAG_WIDTH  broadcast tag
cdb_src_out  output  $clog2(NUM_REQ)  index of the granted unit
cdb_count_out  output  32  number of broadcasts consumed since reset

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high via rst_in.
- Reset values: cdb_valid_out=0, cdb_data_out=0, cdb_tag_out=0, cdb_src_out=0, cdb_count_out=0, round-robin pointer ptr=0. req_ready_out is combinational and reads 0 during rst_in=1.
- can_load = !cdb_valid_out || cdb_ready_in.
- Grant rules:
  - Grant only when can_load && !flush_in && !rst_in.
  - Search order: ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. The first index with req_valid_in high wins.
  - req_ready_out is one-hot or zero. It is combinational from req_valid_in, ptr, cdb_valid_out, cdb_ready_in and flush_in.
- Unit handshake: a transfer occurs when req_valid_in[i] && req_ready_out[i]. A unit holds valid/data/tag stable until it sees ready.
- On grant of unit g (next edge):
  - Output stage loads unit g's data and tag; cdb_src_out=g; cdb_valid_out=1.
  - ptr = (g+1) mod NUM_REQ.
- Latency: 1 cycle from grant to cdb_valid_out.
- Throughput: 1 broadcast/cycle when cdb_ready_in is held high.
- Consume without grant: if the broadcast is consumed (cdb_valid_out && cdb_ready_in) and no grant occurs, cdb_valid_out clears next edge. Data, tag and src hold their last values.
- Backpressure: while cdb_valid_out && !cdb_ready_in, all outputs hold and no grant is issued.
- Counter: cdb_count_out increments by 1 on each consumed broadcast (cdb_valid_out && cdb_ready_in && !flush_in). Wraps modulo 2^32.
- flush_in=1:
  - Next edge: cdb_valid_out=0.
  - No grant this cycle; ptr unchanged; counter not incremented.
  - Data, tag and src hold their last values.
  - Units keep their requests and are arbitrated after the flush deasserts.
- Tag 0: broadcast normally; the arbiter does not filter it. The register file ignores writes to x0.
- Simultaneous consume and grant: output reloads in the same edge with no bubble; counter increments.
- rst_in mid-broadcast: takes priority over everything; the pending broadcast is lost.
- ptr width is $clog2(NUM_REQ). Wrap is explicit modulo NUM_REQ, so non-power-of-2 NUM_REQ never indexes out of range.

Test Plan:
- Single requester: unit 2 valid, data=0x0000_0080, tag=11, cdb_ready_in=1 → req_ready_out=4'b0100 at cycle 0; next cycle cdb_valid_out=1, data 0x80, tag 11, src 2; count=1 after consume; ptr=3.
- Fairness: all 4 units continuously valid, cdb_ready_in=1 for 8 cycles from reset → cdb_src_out sequence 0,1,2,3,0,1,2,3; no cycle without valid after the first; count=8.
- Backpressure: grant unit 1, then cdb_ready_in=0 for 5 cycles with unit 3 valid → outputs frozen at unit 1's values, req_ready_out=0 throughout; on cdb_ready_in=1, unit 3 is granted in that same cycle.
- Flush: broadcast pending (unit 0, tag 5) and units 1 and 2 valid, flush_in pulsed 1 cycle → cdb_valid_out=0 next cycle, count unchanged, ptr=1; following cycle unit 1 is granted.
- Tag 0 / x0: unit 0 sends data=0x1, tag=0 repeatedly for 128 cycles → 128 broadcasts with tag 0; count=128; no filtering.
- Reset mid-operation: rst_in asserted with cdb_valid_out=1 and count=37 → next edge all outputs 0, count 0, ptr 0; after release, first grant goes to the lowest valid index.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Round-robin selection among functional-unit results feeding a single
// registered broadcast stage. The stage supports consumer backpressure and a
// mispredict flush, and it counts every broadcast the consumer takes.
module cdb_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk_100mhz,
   input  logic                            rst_in,
   input  logic [NUM_REQ-1:0]              req_valid_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_in,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag_in,
   output logic [NUM_REQ-1:0]              req_ready_out,
   input  logic                            cdb_ready_in,
   input  logic                            flush_in,
   output logic                            cdb_valid_out,
   output logic [DATA_WIDTH-1:0]           cdb_data_out,
   output logic [TAG_WIDTH-1:0]            cdb_tag_out,
   output logic [PTR_W-1:0]                cdb_src_out,
   output logic [31:0]                     cdb_count_out
);

   // One extra bit so pointer arithmetic can hold values up to 2*NUM_REQ-2
   // before the explicit modulo fold.
   localparam int W1 = PTR_W + 1;

   logic                   r_valid;
   logic [DATA_WIDTH-1:0]  r_data;
   logic [TAG_WIDTH-1:0]   r_tag;
   logic [PTR_W-1:0]       r_src;
   logic [31:0]            r_count;
   logic [PTR_W-1:0]       r_ptr;

   logic                   w_can_load;
   logic                   w_grant_en;
   logic                   w_consume;
   logic [NUM_REQ-1:0]     w_rot;
   logic                   w_found;
   logic [PTR_W-1:0]       w_off;
   logic [W1-1:0]          w_sum;
   logic [PTR_W-1:0]       w_gidx;
   logic [W1-1:0]          w_inc;
   logic [PTR_W-1:0]       w_ptr_nxt;
   logic [NUM_REQ-1:0]     w_grant;
   logic [DATA_WIDTH-1:0]  w_sel_data;
   logic [TAG_WIDTH-1:0]   w_sel_tag;

   assign w_can_load = !r_valid || cdb_ready_in;
   assign w_grant_en = w_can_load && !flush_in && !rst_in;
   assign w_consume  = r_valid && cdb_ready_in;

   // Rotate requests so bit k is unit (ptr+k) mod NUM_REQ; ptr is always
   // below NUM_REQ, so the doubled vector covers every wrap position.
   assign w_rot = NUM_REQ'({req_valid_in, req_valid_in} >> r_ptr);

   // Find the lowest rotated offset with a pending request.
   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = w_grant_en;
            w_off   = PTR_W'(k);
         end
      end
   end

   // Map the rotated offset back to a unit index and compute the next
   // pointer, both folded modulo NUM_REQ without a divider.
   always_comb begin
      w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
      w_gidx = (w_sum >= W1'(NUM_REQ)) ? PTR_W'(w_sum - W1'(NUM_REQ))
                                       : w_sum[PTR_W-1:0];
      w_inc  = {1'b0, w_gidx} + W1'(1);
      w_ptr_nxt = (w_inc >= W1'(NUM_REQ)) ? '0 : w_inc[PTR_W-1:0];
   end

   // One-hot grant vector and the matching result/tag multiplexer.
   always_comb begin
      w_grant    = '0;
      w_sel_data = '0;
      w_sel_tag  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_found && (w_gidx == PTR_W'(i))) begin
            w_grant[i] = 1'b1;
            w_sel_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_tag  = req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   assign req_ready_out = w_grant;

   // Broadcast stage: load on grant, drop on flush or unreplaced consume,
   // otherwise hold. Data/tag/src keep their last values when valid drops.
   always_ff @(posedge clk_100mhz) begin
      if (rst_in) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tag   <= '0;
         r_src   <= '0;
         r_ptr   <= '0;
      end else if (w_found) begin
         r_valid <= 1'b1;
         r_data  <= w_sel_data;
         r_tag   <= w_sel_tag;
         r_src   <= w_gidx;
         r_ptr   <= w_ptr_nxt;
      end else if (flush_in || w_consume) begin
         r_valid <= 1'b0;
      end
   end

   // Count broadcasts actually taken; a flushed broadcast does not count.
   always_ff @(posedge clk_100mhz) begin
      if (rst_in) begin
         r_count <= '0;
      end else if (w_consume && !flush_in) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign cdb_valid_out = r_valid;
   assign cdb_data_out  = r_data;
   assign cdb_tag_out   = r_tag;
   assign cdb_src_out   = r_src;
   assign cdb_count_out = r_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for per-cycle behaviour plus
// hand sequences for tag-0 streaming, fairness and reset mid-operation.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      valid;
   logic [N*DW-1:0]   data;
   logic [N*TW-1:0]   tag;
   logic [N-1:0]      gnt;
   logic              rdy;
   logic              flush;
   logic              cv;
   logic [DW-1:0]     cd;
   logic [TW-1:0]     ct;
   logic [1:0]        cs;
   logic [31:0]       cc;

   logic [DW-1:0] u_data [N];
   logic [TW-1:0] u_tag  [N];

   int checks = 0;
   int errors = 0;

   cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clk_100mhz    (clk),
      .rst_in        (rst),
      .req_valid_in  (valid),
      .req_data_in   (data),
      .req_tag_in    (tag),
      .req_ready_out (gnt),
      .cdb_ready_in  (rdy),
      .flush_in      (flush),
      .cdb_valid_out (cv),
      .cdb_data_out  (cd),
      .cdb_tag_out   (ct),
      .cdb_src_out   (cs),
      .cdb_count_out (cc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic        rdy;
      logic        flush;
      logic [3:0]  exp_gnt;
      logic        exp_v;
      logic [1:0]  exp_src;
      logic [31:0] exp_data;
      logic [3:0]  exp_tag;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic rd, input logic f);
      rst   = r;
      valid = v;
      rdy   = rd;
      flush = f;
      for (int i = 0; i < N; i++) begin
         data[i*DW +: DW] = u_data[i];
         tag[i*TW +: TW]  = u_tag[i];
      end
   endtask

   initial begin
      int n_gnt;
      int n_bc;

      u_data[0] = 32'h0000_00A0; u_tag[0] = 4'd5;
      u_data[1] = 32'h0000_00B1; u_tag[1] = 4'd7;
      u_data[2] = 32'h0000_0080; u_tag[2] = 4'd11;
      u_data[3] = 32'h0000_00D3; u_tag[3] = 4'd3;
      drive(1'b1, 4'b0000, 1'b1, 1'b0);

      //           rst valid    rdy fl  gnt      v  src data          tag    cnt
      vecs[0]  = '{1, 4'b1111, 1, 0, 4'b0000, 0, 0, 32'h0,        4'd0,  32'd0};
      vecs[1]  = '{0, 4'b0100, 1, 0, 4'b0100, 1, 2, 32'h0000_0080, 4'd11, 32'd0};
      vecs[2]  = '{0, 4'b0000, 1, 0, 4'b0000, 0, 2, 32'h0000_0080, 4'd11, 32'd1};
      vecs[3]  = '{0, 4'b1111, 1, 0, 4'b1000, 1, 3, 32'h0000_00D3, 4'd3,  32'd1};
      vecs[4]  = '{0, 4'b1111, 1, 0, 4'b0001, 1, 0, 32'h0000_00A0, 4'd5,  32'd2};
      vecs[5]  = '{0, 4'b1111, 1, 0, 4'b0010, 1, 1, 32'h0000_00B1, 4'd7,  32'd3};
      vecs[6]  = '{0, 4'b1111, 1, 0, 4'b0100, 1, 2, 32'h0000_0080, 4'd11, 32'd4};
      vecs[7]  = '{0, 4'b1111, 1, 0, 4'b1000, 1, 3, 32'h0000_00D3, 4'd3,  32'd5};
      vecs[8]  = '{0, 4'b1000, 0, 0, 4'b0000, 1, 3, 32'h0000_00D3, 4'd3,  32'd5};
      vecs[9]  = '{0, 4'b1000, 0, 0, 4'b0000, 1, 3, 32'h0000_00D3, 4'd3,  32'd5};
      vecs[10] = '{0, 4'b1010, 1, 0, 4'b0010, 1, 1, 32'h0000_00B1, 4'd7,  32'd6};
      vecs[11] = '{0, 4'b0110, 0, 1, 4'b0000, 0, 1, 32'h0000_00B1, 4'd7,  32'd6};
      vecs[12] = '{0, 4'b0110, 1, 0, 4'b0100, 1, 2, 32'h0000_0080, 4'd11, 32'd6};
      vecs[13] = '{0, 4'b0110, 1, 1, 4'b0000, 0, 2, 32'h0000_0080, 4'd11, 32'd6};
      vecs[14] = '{0, 4'b0011, 1, 0, 4'b0001, 1, 0, 32'h0000_00A0, 4'd5,  32'd6};
      vecs[15] = '{1, 4'b1111, 1, 0, 4'b0000, 0, 0, 32'h0,        4'd0,  32'd0};
      vecs[16] = '{0, 4'b0110, 1, 0, 4'b0010, 1, 1, 32'h0000_00B1, 4'd7,  32'd0};
      vecs[17] = '{0, 4'b0000, 0, 0, 4'b0000, 1, 1, 32'h0000_00B1, 4'd7,  32'd0};
      vecs[18] = '{0, 4'b0000, 1, 0, 4'b0000, 0, 1, 32'h0000_00B1, 4'd7,  32'd1};

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].valid, vecs[i].rdy, vecs[i].flush);
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(cv), 32'(vecs[i].exp_v));
         chk($sformatf("v%0d_src", i),   32'(cs), 32'(vecs[i].exp_src));
         chk($sformatf("v%0d_data", i),  cd,      vecs[i].exp_data);
         chk($sformatf("v%0d_tag", i),   32'(ct), 32'(vecs[i].exp_tag));
         chk($sformatf("v%0d_count", i), cc,      vecs[i].exp_cnt);
      end

      // Tag 0 stream from unit 0: one grant and one broadcast every cycle.
      u_data[0] = 32'h1;
      u_tag[0]  = 4'd0;
      @(negedge clk);
      drive(1'b1, 4'b0000, 1'b1, 1'b0);
      n_gnt = 0;
      n_bc  = 0;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         drive(1'b0, 4'b0001, 1'b1, 1'b0);
         #1;
         if (gnt == 4'b0001) n_gnt++;
         @(posedge clk);
         #1;
         if (cv && ct == 4'd0 && cd == 32'h1 && cs == 2'd0) n_bc++;
      end
      @(negedge clk);
      drive(1'b0, 4'b0000, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("tag0_grants", 32'(n_gnt), 32'd128);
      chk("tag0_bcasts", 32'(n_bc), 32'd128);
      chk("tag0_count", cc, 32'd128);
      chk("tag0_drained", 32'(cv), 32'd0);

      // Fairness from reset, then run on until 37 broadcasts are consumed.
      u_data[0] = 32'h0000_00A0;
      u_tag[0]  = 4'd5;
      @(negedge clk);
      drive(1'b1, 4'b0000, 1'b1, 1'b0);
      for (int k = 0; k < 38; k++) begin
         @(negedge clk);
         drive(1'b0, 4'b1111, 1'b1, 1'b0);
         @(posedge clk);
         #1;
         if (k < 8) begin
            chk($sformatf("fair%0d_src", k), 32'(cs), 32'(k % 4));
            chk($sformatf("fair%0d_valid", k), 32'(cv), 32'd1);
         end
      end
      chk("pre_rst_count", cc, 32'd37);
      chk("pre_rst_valid", 32'(cv), 32'd1);

      @(negedge clk);
      drive(1'b1, 4'b1111, 1'b1, 1'b0);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(cv), 32'd0);
      chk("rst_data", cd, 32'd0);
      chk("rst_tag", 32'(ct), 32'd0);
      chk("rst_src", 32'(cs), 32'd0);
      chk("rst_count", cc, 32'd0);

      @(negedge clk);
      drive(1'b0, 4'b1100, 1'b1, 1'b0);
      #1;
      chk("post_rst_gnt", 32'(gnt), 32'b0100);
      @(posedge clk);
      #1;
      chk("post_rst_src", 32'(cs), 32'd2);
      chk("post_rst_data", cd, 32'h0000_0080);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
